// File: rtl/rhd_spi_frame_master.sv
// rhd_spi_frame_master: SPI mode-0 frame master for an RHD2000 headstage.
// Sends 16-bit command frames MSB first under CS. The returning MISO word is
// captured by a separate counter that starts a programmable number of clk
// cycles after CS falls, which absorbs the cable and isolator round trip.
// Optional build macro RHD_MISO_SYNC_EN: MISO passes through a 2-flop
// synchronizer. The sample strobes are delayed by the same two cycles, so
// software offsets keep their meaning.
module rhd_spi_frame_master #(
    parameter int CLKS_PER_HALF = 3,
    parameter int CS_HIGH_CLKS  = 18
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [15:0] data_in,
    input  logic [7:0]  oversample_offset,
    input  logic        MISO,
    output logic        SCLK,
    output logic        MOSI,
    output logic        CS,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        busy
);

    localparam int PERIOD = 32 * CLKS_PER_HALF + CS_HIGH_CLKS;
    localparam int D_MAX  = PERIOD - 1;
    localparam int HW     = $clog2(CLKS_PER_HALF + 1);
    localparam int GW     = $clog2(CS_HIGH_CLKS + 1);
    localparam int DW     = $clog2(PERIOD + 1);

    localparam logic [HW-1:0] HALF_LAST = HW'(CLKS_PER_HALF - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(CS_HIGH_CLKS - 1);
    localparam logic [DW-1:0] D_MAX_V   = DW'(D_MAX);

    typedef enum logic [1:0] {IDLE, SHIFT, CS_GAP} state_t;

    state_t        state_q, state_d;
    logic [14:0]   tx_sh_q, tx_sh_d;
    logic          sclk_q, sclk_d;
    logic          mosi_q, mosi_d;
    logic          cs_q, cs_d;
    logic [HW-1:0] half_q, half_d;
    logic [3:0]    bit_q, bit_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          dly_act_q, dly_act_d;
    logic [DW-1:0] dly_q, dly_d;
    logic          cap_act_q, cap_act_d;
    logic [HW-1:0] cap_half_q, cap_half_d;
    logic          cap_phase_q, cap_phase_d;
    logic [3:0]    cap_bit_q, cap_bit_d;
    logic [14:0]   rx_sh_q, rx_sh_d;
    logic [15:0]   data_out_q, data_out_d;
    logic          data_valid_q, data_valid_d;

    logic [DW-1:0] d_clamp;
    logic          frame_start;
    logic          cap_start;
    logic          samp_stb;
    logic          samp_last;
    logic          samp_en;
    logic          samp_last_en;
    logic          samp_bit;
    logic          pipe_busy;

    // Clamp the sample delay so one capture always ends before the next begins.
    always_comb begin
        if ({24'd0, oversample_offset} > 32'(D_MAX)) d_clamp = D_MAX_V;
        else                                         d_clamp = DW'(oversample_offset);
    end

    // Next state for the frame FSM, the delay counter and the capture counter.
    always_comb begin
        state_d     = state_q;
        tx_sh_d     = tx_sh_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        cs_d        = cs_q;
        half_d      = half_q;
        bit_d       = bit_q;
        gap_d       = gap_q;
        dly_act_d   = dly_act_q;
        dly_d       = dly_q;
        cap_act_d   = cap_act_q;
        cap_half_d  = cap_half_q;
        cap_phase_d = cap_phase_q;
        cap_bit_d   = cap_bit_q;
        frame_start = 1'b0;
        cap_start   = 1'b0;
        samp_stb    = 1'b0;
        samp_last   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) frame_start = 1'b1;
            end
            SHIFT: begin
                if (half_q == HALF_LAST) begin
                    half_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == 4'd15) begin
                            cs_d    = 1'b1;
                            mosi_d  = 1'b0;
                            gap_d   = '0;
                            state_d = CS_GAP;
                        end else begin
                            bit_d   = bit_q + 4'd1;
                            mosi_d  = tx_sh_q[14];
                            tx_sh_d = {tx_sh_q[13:0], 1'b0};
                        end
                    end
                end else begin
                    half_d = half_q + HW'(1);
                end
            end
            CS_GAP: begin
                // The gap's last cycle doubles as the IDLE start check.
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                    if (start) frame_start = 1'b1;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (dly_act_q) begin
            if (dly_q == DW'(1)) begin
                dly_act_d = 1'b0;
                cap_start = 1'b1;
            end else begin
                dly_d = dly_q - DW'(1);
            end
        end

        // The capture counter replays the SCLK timeline; samples land on its rising edges.
        if (cap_act_q) begin
            if (cap_half_q == HALF_LAST) begin
                cap_half_d  = '0;
                cap_phase_d = ~cap_phase_q;
                if (!cap_phase_q) begin
                    samp_stb  = 1'b1;
                    samp_last = (cap_bit_q == 4'd15);
                    cap_bit_d = cap_bit_q + 4'd1;
                    if (cap_bit_q == 4'd15) cap_act_d = 1'b0;
                end
            end else begin
                cap_half_d = cap_half_q + HW'(1);
            end
        end

        if (frame_start) begin
            state_d = SHIFT;
            cs_d    = 1'b0;
            sclk_d  = 1'b0;
            mosi_d  = data_in[15];
            tx_sh_d = data_in[14:0];
            half_d  = '0;
            bit_d   = '0;
            if (d_clamp == '0) begin
                cap_start = 1'b1;
            end else begin
                dly_act_d = 1'b1;
                dly_d     = d_clamp;
            end
        end

        if (cap_start) begin
            cap_act_d   = 1'b1;
            cap_half_d  = '0;
            cap_phase_d = 1'b0;
            cap_bit_d   = '0;
        end
    end

`ifdef RHD_MISO_SYNC_EN
    logic       miso_s1_q, miso_s2_q;
    logic [1:0] stb_pipe_q, last_pipe_q;

    // Synchronize MISO and delay the sample strobes by the same two cycles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            miso_s1_q   <= 1'b0;
            miso_s2_q   <= 1'b0;
            stb_pipe_q  <= '0;
            last_pipe_q <= '0;
        end else begin
            miso_s1_q   <= MISO;
            miso_s2_q   <= miso_s1_q;
            stb_pipe_q  <= {stb_pipe_q[0], samp_stb};
            last_pipe_q <= {last_pipe_q[0], samp_last};
        end
    end

    assign samp_en      = stb_pipe_q[1];
    assign samp_last_en = last_pipe_q[1];
    assign samp_bit     = miso_s2_q;
    assign pipe_busy    = |stb_pipe_q;
`else
    assign samp_en      = samp_stb;
    assign samp_last_en = samp_last;
    assign samp_bit     = MISO;
    assign pipe_busy    = 1'b0;
`endif

    // Shift the sampled MISO bits in and publish the word on the 16th sample.
    always_comb begin
        rx_sh_d      = rx_sh_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        if (samp_en) begin
            rx_sh_d = {rx_sh_q[13:0], samp_bit};
            if (samp_last_en) begin
                data_out_d   = {rx_sh_q, samp_bit};
                data_valid_d = 1'b1;
            end
        end
    end

    // State registers; reset aborts any frame or capture in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            tx_sh_q      <= '0;
            sclk_q       <= 1'b0;
            mosi_q       <= 1'b0;
            cs_q         <= 1'b1;
            half_q       <= '0;
            bit_q        <= '0;
            gap_q        <= '0;
            dly_act_q    <= 1'b0;
            dly_q        <= '0;
            cap_act_q    <= 1'b0;
            cap_half_q   <= '0;
            cap_phase_q  <= 1'b0;
            cap_bit_q    <= '0;
            rx_sh_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tx_sh_q      <= tx_sh_d;
            sclk_q       <= sclk_d;
            mosi_q       <= mosi_d;
            cs_q         <= cs_d;
            half_q       <= half_d;
            bit_q        <= bit_d;
            gap_q        <= gap_d;
            dly_act_q    <= dly_act_d;
            dly_q        <= dly_d;
            cap_act_q    <= cap_act_d;
            cap_half_q   <= cap_half_d;
            cap_phase_q  <= cap_phase_d;
            cap_bit_q    <= cap_bit_d;
            rx_sh_q      <= rx_sh_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign SCLK       = sclk_q;
    assign MOSI       = mosi_q;
    assign CS         = cs_q;
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign busy       = (state_q != IDLE) || dly_act_q || cap_act_q || pipe_busy;

endmodule

// File: tb/tb_rhd_spi_frame_master.sv
// Directed bench for rhd_spi_frame_master with a headstage slave model.
`timescale 1ns/1ps
module tb_rhd_spi_frame_master;

`ifdef RHD_MISO_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [15:0] data_in = '0;
    logic [7:0]  oversample_offset = '0;
    logic        MISO;
    logic        SCLK, MOSI, CS, data_valid, busy;
    logic [15:0] data_out;

    int n_assert = 0;
    int n_fail = 0;

    // slave model state
    int          miso_mode = 0;          // 0: response word, 1: MOSI loopback delayed 5 clk
    logic [15:0] resp_w = '0;
    logic        resp_bit = 1'b0;
    int          sidx = 0;
    logic [4:0]  mosi_hist = '0;

    // monitor state
    int          cyc = 0;
    logic        cs_prev = 1'b1, sclk_prev = 1'b0;
    int          n_cs_fall = 0, last_fall_cyc = -1, last_period = 0;
    int          cs_hi_run = 0, last_gap = 0;
    logic [15:0] rx_word = '0;
    int          rx_bits = 0, sclk_cs_hi = 0;
    int          dv_cnt = 0, dv_cyc = 0;

    rhd_spi_frame_master dut (
        .clk               (clk),
        .rstn              (rstn),
        .start             (start),
        .data_in           (data_in),
        .oversample_offset (oversample_offset),
        .MISO              (MISO),
        .SCLK              (SCLK),
        .MOSI              (MOSI),
        .CS                (CS),
        .data_out          (data_out),
        .data_valid        (data_valid),
        .busy              (busy)
    );

    always #4.464 clk = ~clk;

    assign MISO = (miso_mode == 1) ? mosi_hist[4] : resp_bit;

    always @(posedge clk) mosi_hist <= {mosi_hist[3:0], MOSI};

    always @(negedge clk) begin
        cyc++;
        if (cs_prev && !CS) begin
            n_cs_fall++;
            if (last_fall_cyc >= 0) last_period = cyc - last_fall_cyc;
            last_fall_cyc = cyc;
            last_gap = cs_hi_run;
            rx_word = '0;
            rx_bits = 0;
            sidx = 0;
            resp_bit = resp_w[15];
        end
        if (!sclk_prev && SCLK) begin
            if (!CS) begin
                rx_word = {rx_word[14:0], MOSI};
                rx_bits++;
            end else begin
                sclk_cs_hi++;
            end
        end
        if (sclk_prev && !SCLK && !CS) begin
            sidx++;
            if (sidx < 16) resp_bit = resp_w[15 - sidx];
        end
        if (CS) cs_hi_run++;
        else    cs_hi_run = 0;
        if (data_valid) begin
            dv_cnt++;
            dv_cyc = cyc;
        end
        cs_prev = CS;
        sclk_prev = SCLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_not_busy(input string tag, input int budget);
        int k = 0;
        while (busy && k < budget) begin
            tick();
            k++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    // One frame: start for one clk, then scramble inputs to prove they were latched.
    task automatic run_frame(input string tag, input logic [15:0] cmd, input logic [7:0] off);
        tick();
        data_in = cmd;
        oversample_offset = off;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy_hi"}, 32'(busy), 32'd1);
        data_in = ~cmd;
        oversample_offset = 8'h5A;
        wait_not_busy({tag, "_busy_lo"}, 400);
        repeat (25) tick();
    endtask

    initial begin
        int f0, d0, k;

        // reset values during and after reset
        #50;
        check("rst_cs", 32'(CS), 32'd1);
        check("rst_sclk", 32'(SCLK), 32'd0);
        check("rst_mosi", 32'(MOSI), 32'd0);
        check("rst_dout", 32'(data_out), 32'd0);
        check("rst_dv", 32'(data_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        #46;
        rstn = 1'b1;
        repeat (3) tick();
        check("post_rst_cs", 32'(CS), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);

        // single frame, zero offset, response word
        miso_mode = 0;
        resp_w = 16'h3C96;
        f0 = n_cs_fall; d0 = dv_cnt;
        run_frame("single", 16'hFF00, 8'd0);
        check("single_frames", 32'(n_cs_fall - f0), 32'd1);
        check("single_sclk_pulses", 32'(rx_bits), 32'd16);
        check("single_slave_rx", 32'(rx_word), 32'h0000FF00);
        check("single_dv_count", 32'(dv_cnt - d0), 32'd1);
        check("single_dout", 32'(data_out), 32'h00003C96);
        check("single_cs_gap", 32'(cs_hi_run >= 18), 32'd1);
        check("single_idle_mosi", 32'(MOSI), 32'd0);

        // zero offset, two back-to-back frames of the channel-15 response
        resp_w = 16'hA5C3;
        f0 = n_cs_fall; d0 = dv_cnt;
        tick();
        data_in = 16'h0F00;
        oversample_offset = 8'd0;
        start = 1'b1;
        repeat (150) tick();
        start = 1'b0;
        wait_not_busy("zero_busy_lo", 400);
        check("zero_frames", 32'(n_cs_fall - f0), 32'd2);
        check("zero_dv_count", 32'(dv_cnt - d0), 32'd2);
        check("zero_dout", 32'(data_out), 32'h0000A5C3);
        check("zero_period", 32'(last_period), 32'd114);

        // delayed loopback with matching offset
        miso_mode = 1;
        d0 = dv_cnt;
        run_frame("loop5", 16'h1234, 8'd5);
        check("loop5_dout", 32'(data_out), 32'h00001234);
        check("loop5_dv_count", 32'(dv_cnt - d0), 32'd1);
        check("loop5_latency", 32'(dv_cyc - last_fall_cyc), 32'(93 + 5 + SYNC_LAT));

        // same loopback, offset 0: every bit lands one bit late
        run_frame("loop0", 16'h1234, 8'd0);
        check("loop0_dout", 32'(data_out), 32'h0000091A);

        // offset beyond the frame period is clamped to 113
        d0 = dv_cnt;
        run_frame("clamp", 16'hFFFF, 8'd200);
        check("clamp_latency", 32'(dv_cyc - last_fall_cyc), 32'(93 + 113 + SYNC_LAT));
        check("clamp_dout", 32'(data_out), 32'd0);
        check("clamp_dv_count", 32'(dv_cnt - d0), 32'd1);

        // continuous run for 9000 ns
        miso_mode = 0;
        resp_w = 16'h0F0F;
        f0 = n_cs_fall; d0 = dv_cnt;
        tick();
        data_in = 16'h8001;
        oversample_offset = 8'd0;
        start = 1'b1;
        #9000;
        start = 1'b0;
        wait_not_busy("cont_busy_lo", 400);
        repeat (300) tick();
        check("cont_frames", 32'(n_cs_fall - f0), 32'd9);
        check("cont_dv_count", 32'(dv_cnt - d0), 32'd9);
        check("cont_period", 32'(last_period), 32'd114);
        check("cont_gap", 32'(last_gap), 32'd18);
        check("cont_dout", 32'(data_out), 32'h00000F0F);
        check("cont_cs_idle", 32'(CS), 32'd1);
        check("cont_slave_rx", 32'(rx_word), 32'h00008001);

        // abort with reset during SCLK pulse 8
        resp_w = 16'hFFFF;
        d0 = dv_cnt;
        tick();
        data_in = 16'hAAAA;
        start = 1'b1;
        k = 0;
        while (CS && k < 50) begin tick(); k++; end
        check("abort_cs_low", 32'(CS), 32'd0);
        k = 0;
        while (rx_bits < 8 && k < 200) begin tick(); k++; end
        check("abort_pulse8", 32'(rx_bits), 32'd8);
        rstn = 1'b0;
        start = 1'b0;
        #1;
        check("abort_cs", 32'(CS), 32'd1);
        check("abort_sclk", 32'(SCLK), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        repeat (150) tick();
        check("abort_no_dv", 32'(dv_cnt - d0), 32'd0);
        rstn = 1'b1;
        tick();
        check("abort_dout_cleared", 32'(data_out), 32'd0);

        // normal frame after abort
        resp_w = 16'h1E2D;
        d0 = dv_cnt;
        run_frame("recover", 16'hC33C, 8'd0);
        check("recover_slave_rx", 32'(rx_word), 32'h0000C33C);
        check("recover_dout", 32'(data_out), 32'h00001E2D);
        check("recover_dv_count", 32'(dv_cnt - d0), 32'd1);
        check("no_sclk_cs_high", 32'(sclk_cs_hi), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rhd_spi_frame_master.md
Name: rhd_spi_frame_master

Overview:
- SPI master for an Intan RHD2000-family headstage.
- Issues 16-bit command frames, MSB first, SPI mode 0, with CS framing.
- Captures the returned 16-bit MISO word at a programmable delay after each SCLK rising edge, to absorb cable and isolator round-trip latency.
- Sits between the acquisition sequencer (command source, result sink) and the headstage pins; runs on the fast system clock (112 MHz nominal).

Parameters:
- CLKS_PER_HALF, 3: clk cycles per SCLK half-period. Default gives 112/6 ≈ 18.7 MHz SCLK. Must be ≥ 2.
- CS_HIGH_CLKS, 18: minimum clk cycles CS stays high between frames (≈160 ns at 112 MHz). Must be ≥ 1.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rstn  in  1  asynchronous active-low reset
- start  in  1  level-sensitive run enable; frames repeat back-to-back while high
- data_in  in  16  command word, latched at each frame start
- oversample_offset  in  8  MISO sample delay in clk cycles, latched at each frame start
- MISO  in  1  serial data from the slave
- SCLK  out  1  serial clock, idle low
- MOSI  out  1  serial data to the slave
- CS  out  1  chip select, active low
- data_out  out  16  last captured MISO word
- data_valid  out  1  one-cycle pulse when data_out updates
- busy  out  1  high from frame start until both shift-out and capture finish

Behaviour:
- Reset (async, rstn=0): CS=1, SCLK=0, MOSI=0, data_out=0, data_valid=0, busy=0; all counters cleared; FSM to IDLE. Asserting reset mid-frame aborts immediately; there is no partial data_valid.
- FSM states: IDLE, SHIFT, CS_GAP.
- IDLE: on a clk edge with start=1, latch data_in and oversample_offset, set frame cycle t=0, drive CS=0 and MOSI=data_in[15], go to SHIFT.
- SHIFT, with H=CLKS_PER_HALF and frame cycle t counted from CS fall, bit index i=0..15 from the MSB:
  - SCLK rises at t=H(2i+1) and falls at t=2H(i+1).
  - MOSI changes to the next bit at each falling edge, so it is stable ≥H cycles around each rising edge.
  - After the 16th falling edge (t=32H): CS=1, MOSI=0, go to CS_GAP.
- CS_GAP: hold CS=1 for CS_HIGH_CLKS cycles, then go to IDLE. IDLE re-checks start in the same cycle, so back-to-back frame period = 32H+CS_HIGH_CLKS clk cycles (114 with defaults).
- start low mid-frame: the current frame and its capture complete normally; no further frame starts.
- data_in or oversample_offset changing mid-frame: ignored until the next frame start.
- Capture, with the latched offset D = min(oversample_offset, 32H+CS_HIGH_CLKS−1):
  - MISO is shifted into the capture register MSB first at clk edges t=H(2i+1)+D, i=0..15.
  - Capture runs in an independent capture counter started D cycles after CS fall, so it may extend past CS rise.
- Capture completion:
  - On the cycle after the 16th sample, data_out is updated and data_valid pulses for 1 cycle.
  - busy drops once both the FSM is back in IDLE and capture is complete.
  - The D clamp guarantees a frame's capture finishes before the next frame's capture begins.

Optional Feature:
- Macro RHD_MISO_SYNC_EN.
- Defined: MISO passes through a 2-flop synchronizer before the capture register. The sample for bit i is taken at t=H(2i+1)+D+2; the two-cycle penalty is applied internally, so software offsets are unchanged.
- Undefined: MISO is sampled directly, at exactly t=H(2i+1)+D.

Test Plan:
- Reset values: pulse rstn low 100 ns → CS=1, SCLK=0, MOSI=0, data_out=0, data_valid=0, busy=0 during and after reset.
- Single frame: data_in=16'hFF00, start high for 1 frame then low → exactly 16 SCLK pulses while CS=0; slave receives 16'hFF00; CS high ≥18 clk afterwards.
- Zero offset: slave drives 16'hA5C3 (channel-15 response model), offset=0, MISO valid at rising edges → data_out=16'hA5C3 with one data_valid pulse per frame.
- Delayed loopback: MISO = MOSI delayed 5 clk, offset=5, data_in=16'h1234 → data_out=16'h1234. With offset=0 on the same model → a mismatching word.
- Continuous run: start held 9000 ns at 112 MHz → 9 frames, period 114 clk, 9 data_valid pulses. After start drops, the in-flight frame completes and CS stays high.
- Abort: rstn low at SCLK pulse 8 of a frame → CS=1 and SCLK=0 immediately, no data_valid. Normal frame with correct data after rstn returns high.
